mcb_sample_logger: RTL and testbench

- Consumes clk0/rst0 and the MCB calibration-done status from the memory infrastructure/controller wrapper.
- Streams 32-bit servo samples into one MCB user write port and issues fixed-length write bursts to a circular address region in DDR.
- Sits between the servo data path and the MCB user port. It is the first user-side logic clocked by clk0 after reset release.

---
 rtl/mcb_sample_logger.sv | 147 ++++++++++++++
 tb/tb_mcb_sample_logger.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcb_sample_logger.sv
// Streams 32-bit servo samples into an MCB user write port and issues fixed-length
// write bursts over a circular DDR region. Optional drop counter: MCB_SAMPLE_LOGGER_DROP_CNT_EN.
module mcb_sample_logger #(
  parameter int          BURST_LEN    = 16,
  parameter logic [29:0] BASE_ADDR    = 30'h0,
  parameter logic [29:0] REGION_BYTES = 30'h0100_0000
) (
  input  logic        clk0,
  input  logic        rst0,
  input  logic        calib_done,
  input  logic        enable,
  input  logic        s_valid,
  input  logic [31:0] s_data,
  output logic        p_cmd_en,
  output logic [2:0]  p_cmd_instr,
  output logic [5:0]  p_cmd_bl,
  output logic [29:0] p_cmd_byte_addr,
  input  logic        p_cmd_full,
  output logic        p_wr_en,
  output logic [31:0] p_wr_data,
  output logic [3:0]  p_wr_mask,
  input  logic        p_wr_full,
  output logic        wrap_pulse,
  output logic [15:0] drop_count,
  output logic        busy,
  output logic [1:0]  state_dbg,
  output logic [6:0]  pending_dbg
);

  // Handshake: p_wr_en / p_cmd_en are single-cycle strobes; one word / one command
  // transfers in every cycle its strobe is high. The full flags are sampled in the
  // cycle before a strobe is raised, so a strobe never follows a full cycle.

  typedef enum logic [1:0] {
    WAIT_CAL = 2'd0,
    RUN      = 2'd1,
    ISSUED   = 2'd2
  } state_t;

  localparam logic [6:0]  BL7      = 7'(BURST_LEN);
  localparam logic [30:0] STEP     = 31'(BURST_LEN * 4);
  localparam logic [30:0] END_ADDR = {1'b0, BASE_ADDR} + {1'b0, REGION_BYTES};

  state_t      state, state_nxt;
  logic        cmd_en_nxt;
  logic        accept;
  logic [6:0]  pending;
  logic [30:0] addr_inc;

  assign p_cmd_instr = 3'b000;
  assign p_cmd_bl    = 6'(BURST_LEN - 1);
  assign p_wr_mask   = 4'b0000;
  assign busy        = (pending != 7'd0);
  assign state_dbg   = state;
  assign pending_dbg = pending;

  assign accept   = s_valid & enable & (state != WAIT_CAL) & ~p_wr_full;
  assign addr_inc = {1'b0, p_cmd_byte_addr} + STEP;

  always_comb begin
    state_nxt  = state;
    cmd_en_nxt = 1'b0;
    case (state)
      WAIT_CAL: if (calib_done) state_nxt = RUN;
      RUN: begin
        // Only issue once every word of the burst is already in the write FIFO.
        if (pending >= BL7 && !p_cmd_full) begin
          cmd_en_nxt = 1'b1;
          state_nxt  = ISSUED;
        end
      end
      ISSUED:  state_nxt = RUN;
      default: state_nxt = WAIT_CAL;
    endcase
  end

  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      state    <= WAIT_CAL;
      p_cmd_en <= 1'b0;
    end else begin
      state    <= state_nxt;
      p_cmd_en <= cmd_en_nxt;
    end
  end

  // Address advances after the command cycle, so it is stable while p_cmd_en is high.
  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      p_cmd_byte_addr <= BASE_ADDR;
      wrap_pulse      <= 1'b0;
    end else begin
      wrap_pulse <= 1'b0;
      if (state == ISSUED) begin
        if (addr_inc == END_ADDR) begin
          p_cmd_byte_addr <= BASE_ADDR;
          wrap_pulse      <= 1'b1;
        end else begin
          p_cmd_byte_addr <= addr_inc[29:0];
        end
      end
    end
  end

  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      p_wr_en   <= 1'b0;
      p_wr_data <= 32'h0;
    end else begin
      p_wr_en <= accept;
      if (accept) p_wr_data <= s_data;
    end
  end

  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      pending <= 7'd0;
    end else begin
      pending <= pending + {6'd0, p_wr_en} - (p_cmd_en ? BL7 : 7'd0);
    end
  end

`ifdef MCB_SAMPLE_LOGGER_DROP_CNT_EN
  logic        enable_q;
  logic        drop;
  logic [15:0] drop_cnt;

  assign drop = s_valid & enable & (state != WAIT_CAL) & p_wr_full;

  // A rising enable restarts the count; a drop in that same cycle is the first one.
  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      enable_q <= 1'b0;
      drop_cnt <= 16'h0000;
    end else begin
      enable_q <= enable;
      if (enable && !enable_q) drop_cnt <= {15'd0, drop};
      else if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  assign drop_count = drop_cnt;
`else
  assign drop_count = 16'h0000;
`endif

endmodule

// File: tb/tb_mcb_sample_logger.sv
// Self-checking bench for mcb_sample_logger: randomized and directed samples, a
// behavioural model feeding expected queues, and a negedge monitor that compares.
module tb_mcb_sample_logger;

  localparam int          BL     = 16;
  localparam logic [29:0] BASE   = 30'h100;
  localparam logic [29:0] REGION = 30'd128;
  localparam int          LAST_A = int'(BASE) + int'(REGION) - BL * 4;

  logic        clk0 = 1'b0;
  logic        rst0 = 1'b1;
  logic        calib_done = 1'b0;
  logic        enable = 1'b0;
  logic        s_valid = 1'b0;
  logic [31:0] s_data = 32'h0;
  logic        p_cmd_full = 1'b0;
  logic        p_wr_full = 1'b0;
  logic        p_cmd_en, p_wr_en, wrap_pulse, busy;
  logic [2:0]  p_cmd_instr;
  logic [5:0]  p_cmd_bl;
  logic [29:0] p_cmd_byte_addr;
  logic [31:0] p_wr_data;
  logic [3:0]  p_wr_mask;
  logic [15:0] drop_count;
  logic [1:0]  state_dbg;
  logic [6:0]  pending_dbg;

  mcb_sample_logger #(.BURST_LEN(BL), .BASE_ADDR(BASE), .REGION_BYTES(REGION)) dut (
    .clk0(clk0), .rst0(rst0), .calib_done(calib_done), .enable(enable),
    .s_valid(s_valid), .s_data(s_data), .p_cmd_en(p_cmd_en), .p_cmd_instr(p_cmd_instr),
    .p_cmd_bl(p_cmd_bl), .p_cmd_byte_addr(p_cmd_byte_addr), .p_cmd_full(p_cmd_full),
    .p_wr_en(p_wr_en), .p_wr_data(p_wr_data), .p_wr_mask(p_wr_mask), .p_wr_full(p_wr_full),
    .wrap_pulse(wrap_pulse), .drop_count(drop_count), .busy(busy),
    .state_dbg(state_dbg), .pending_dbg(pending_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk0 = ~clk0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_wr_q[$];
  logic [29:0] exp_cmd_q[$];
  int n_checks = 0, n_err = 0;
  // model
  bit m_cal = 0, m_en_prev = 0;
  int m_words = 0, m_bursts = 0, m_wraps = 0, m_drops = 0;
  // monitor
  int cyc = 0, wr_seen = 0, wr_p1 = 0, wr_p2 = 0, cmd_seen = 0, wrap_seen = 0;
  int last_wr_cyc = -100, last_cmd_cyc = -100;
  logic prev_cmd_full = 1'b0, prev_cmd_en = 1'b0;
  logic [29:0] prev_addr = 30'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int exp_drops();
`ifdef MCB_SAMPLE_LOGGER_DROP_CNT_EN
    return m_drops;
`else
    return 0;
`endif
  endfunction

  // Behavioural model: every BL accepted words form one burst; bursts walk the region.
  task automatic model_update();
    if (enable && !m_en_prev) m_drops = 0;
    if (s_valid && enable && m_cal) begin
      if (!p_wr_full) begin
        exp_wr_q.push_back(s_data);
        m_words++;
        if (m_words % BL == 0) begin
          exp_cmd_q.push_back(30'(int'(BASE) + (m_bursts * BL * 4) % int'(REGION)));
          m_bursts++;
          if ((m_bursts * BL * 4) % int'(REGION) == 0) m_wraps++;
        end
      end else if (m_drops != 16'hFFFF) begin
        m_drops++;
      end
    end
    m_en_prev = enable;
    if (calib_done) m_cal = 1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic sv, input logic [31:0] d, input logic en,
                      input logic wf, input logic cf);
    s_valid = sv; s_data = d; enable = en; p_wr_full = wf; p_cmd_full = cf;
    @(posedge clk0);
    model_update();
    #1;
  endtask

  task automatic idle(input int n, input logic cf);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b1, 1'b0, cf);
  endtask

  task automatic samples(input int n);
    for (int i = 0; i < n; i++) step(1'b1, $urandom, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic reset_hold();
    rst0 = 1'b1;
    calib_done = 1'b0;
    s_valid = 1'b0;
    exp_wr_q.delete();
    exp_cmd_q.delete();
    m_cal = 0; m_en_prev = 0; m_words = 0; m_bursts = 0; m_drops = 0;
    wr_seen = 0; wr_p1 = 0; wr_p2 = 0; cmd_seen = 0;
    repeat (2) @(posedge clk0);
    #1 rst0 = 1'b0;
  endtask

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk0);
      cyc++;
      wr_p2 = wr_p1;
      wr_p1 = wr_seen;
      if (!rst0) begin
        if (p_cmd_en) begin
          chk("cmd_expected", 32'(exp_cmd_q.size() != 0), 32'd1);
          if (exp_cmd_q.size() != 0) chk("cmd_addr", 32'(p_cmd_byte_addr), 32'(exp_cmd_q.pop_front()));
          chk("cmd_bl", 32'(p_cmd_bl), 32'(BL - 1));
          chk("cmd_instr", 32'(p_cmd_instr), 32'd0);
          chk("wr_mask", 32'(p_wr_mask), 32'd0);
          chk("cmd_after_full", 32'(prev_cmd_full), 32'd0);
          chk("cmd_words_ready", 32'(wr_p2 >= BL * (cmd_seen + 1)), 32'd1);
          chk("cmd_spacing", 32'((cyc - last_cmd_cyc) >= 2), 32'd1);
          cmd_seen++;
          last_cmd_cyc = cyc;
        end
        if (p_wr_en) begin
          chk("wr_expected", 32'(exp_wr_q.size() != 0), 32'd1);
          if (exp_wr_q.size() != 0) chk("wr_data", p_wr_data, exp_wr_q.pop_front());
          wr_seen++;
          last_wr_cyc = cyc;
        end
        if (wrap_pulse) begin
          wrap_seen++;
          chk("wrap_after_cmd", 32'(prev_cmd_en), 32'd1);
          chk("wrap_prev_addr", 32'(prev_addr), 32'(LAST_A));
          chk("wrap_addr_base", 32'(p_cmd_byte_addr), 32'(BASE));
        end
      end
      prev_cmd_full = p_cmd_full;
      prev_cmd_en   = p_cmd_en;
      prev_addr     = p_cmd_byte_addr;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int pre;
    reset_hold();
    chk("rst_cmd_en", 32'(p_cmd_en), 32'd0);
    chk("rst_wr_en", 32'(p_wr_en), 32'd0);
    chk("rst_addr", 32'(p_cmd_byte_addr), 32'(BASE));
    chk("rst_wrap", 32'(wrap_pulse), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    chk("rst_state", 32'(state_dbg), 32'd0);
    chk("rst_bl", 32'(p_cmd_bl), 32'(BL - 1));

    // 1: samples before calibration are ignored
    samples(20);
    idle(3, 1'b0);
    chk("t1_no_wr", 32'(wr_seen), 32'd0);
    chk("t1_no_cmd", 32'(cmd_seen), 32'd0);
    chk("t1_drop", 32'(drop_count), 32'd0);
    chk("t1_state", 32'(state_dbg), 32'd0);

    // 2: one full burst of 0..15
    calib_done = 1'b1;
    idle(1, 1'b0);
    for (int i = 0; i < BL; i++) step(1'b1, 32'(i), 1'b1, 1'b0, 1'b0);
    idle(6, 1'b0);
    chk("t2_wr_count", 32'(wr_seen), 32'(BL));
    chk("t2_cmd_count", 32'(cmd_seen), 32'd1);
    chk("t2_cmd_latency", 32'(last_cmd_cyc - last_wr_cyc), 32'd2);
    chk("t2_next_addr", 32'(p_cmd_byte_addr), 32'(BASE) + 32'(BL * 4));
    chk("t2_busy", 32'(busy), 32'd0);

    // 3: three more bursts across the wrap point
    samples(48);
    idle(8, 1'b0);
    chk("t3_cmd_count", 32'(cmd_seen), 32'd4);
    chk("t3_wraps", 32'(wrap_seen), 32'd2);
    chk("t3_addr", 32'(p_cmd_byte_addr), 32'(BASE));

    // 4: command FIFO full defers commands
    for (int i = 0; i < 40; i++) step(1'b1, $urandom, 1'b1, 1'b0, 1'b1);
    idle(5, 1'b1);
    chk("t4_no_cmd_full", 32'(cmd_seen), 32'd4);
    chk("t4_pending_40", 32'(pending_dbg), 32'd40);
    chk("t4_busy", 32'(busy), 32'd1);
    idle(10, 1'b0);
    chk("t4_cmds_released", 32'(cmd_seen), 32'd6);
    chk("t4_pending_8", 32'(pending_dbg), 32'd8);

    // 5: write FIFO full drops samples
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, $urandom, 1'b1, 1'b1, 1'b0);
    idle(4, 1'b0);
`ifdef MCB_SAMPLE_LOGGER_DROP_CNT_EN
    chk("t5_drop_5", 32'(drop_count), 32'd5);
`else
    chk("t5_drop_0", 32'(drop_count), 32'd0);
`endif
    chk("t5_drop_model", 32'(drop_count), 32'(exp_drops()));
    chk("t5_pending", 32'(pending_dbg), 32'd8);

    // random phase
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 15) != 0),
           1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0));
    idle(20, 1'b0);
    chk("rnd_drop", 32'(drop_count), 32'(exp_drops()));
    chk("rnd_pending", 32'(pending_dbg), 32'(m_words % BL));
    chk("rnd_busy", 32'(busy), 32'((m_words % BL) != 0));
    chk("rnd_wraps", 32'(wrap_seen), 32'(m_wraps));

    // 6: reset mid-burst after 7 samples
    pre = m_words % BL;
    if (pre + 7 >= BL) begin
      samples(BL - pre);
      idle(6, 1'b0);
    end
    samples(7);
    #2 rst0 = 1'b1;
    #1;
    chk("t6_cmd_en", 32'(p_cmd_en), 32'd0);
    chk("t6_wr_en", 32'(p_wr_en), 32'd0);
    chk("t6_addr", 32'(p_cmd_byte_addr), 32'(BASE));
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_state", 32'(state_dbg), 32'd0);
    chk("t6_pending", 32'(pending_dbg), 32'd0);
    reset_hold();
    calib_done = 1'b1;
    idle(1, 1'b0);
    samples(BL + 3);
    idle(6, 1'b0);
    chk("t6_post_cmds", 32'(cmd_seen), 32'd1);
    chk("t6_post_pending", 32'(pending_dbg), 32'd3);

    // final report
    chk("end_wr_q_empty", 32'(exp_wr_q.size()), 32'd0);
    chk("end_cmd_q_empty", 32'(exp_cmd_q.size()), 32'd0);
    chk("end_wraps", 32'(wrap_seen), 32'(m_wraps));
    chk("end_drop", 32'(drop_count), 32'(exp_drops()));
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
